// File: rtl/kernel3_gmem_c_m_axi_write_burst_split_if.sv
// Handshake bundle for the gmem_C write burst splitter: request channel,
// flat beat stream, and the AXI AW/W outputs.
// The master modport is the splitter's view. The slave modport is the view
// of the environment that drives requests and beats and consumes bursts.
interface kernel3_gmem_c_m_axi_write_burst_split_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0]   in_REQ_ADDR;
  logic [LEN_WIDTH-1:0]    in_REQ_LEN;
  logic                    in_REQ_VALID;
  logic                    out_REQ_READY;
  logic [DATA_WIDTH-1:0]   in_DATA;
  logic [DATA_WIDTH/8-1:0] in_STRB;
  logic                    in_DATA_VALID;
  logic                    out_DATA_READY;
  logic [ADDR_WIDTH-1:0]   out_BUS_AWADDR;
  logic [7:0]              out_BUS_AWLEN;
  logic                    out_BUS_AWVALID;
  logic                    in_BUS_AWREADY;
  logic [DATA_WIDTH-1:0]   out_BUS_WDATA;
  logic [DATA_WIDTH/8-1:0] out_BUS_WSTRB;
  logic                    out_BUS_WLAST;
  logic                    out_BUS_WVALID;
  logic                    in_BUS_WREADY;

  modport master (
    input  in_REQ_ADDR, in_REQ_LEN, in_REQ_VALID,
    input  in_DATA, in_STRB, in_DATA_VALID,
    input  in_BUS_AWREADY, in_BUS_WREADY,
    output out_REQ_READY, out_DATA_READY,
    output out_BUS_AWADDR, out_BUS_AWLEN, out_BUS_AWVALID,
    output out_BUS_WDATA, out_BUS_WSTRB, out_BUS_WLAST, out_BUS_WVALID
  );

  modport slave (
    output in_REQ_ADDR, in_REQ_LEN, in_REQ_VALID,
    output in_DATA, in_STRB, in_DATA_VALID,
    output in_BUS_AWREADY, in_BUS_WREADY,
    input  out_REQ_READY, out_DATA_READY,
    input  out_BUS_AWADDR, out_BUS_AWLEN, out_BUS_AWVALID,
    input  out_BUS_WDATA, out_BUS_WSTRB, out_BUS_WLAST, out_BUS_WVALID
  );
endinterface

// File: rtl/kernel3_gmem_c_m_axi_write_burst_split.sv
// gmem_C write burst splitter.
// It turns one (address, beat count) request into AXI AW bursts. Each burst is
// at most MAX_BURST beats and never crosses a BOUNDARY-byte line. A small
// queue of burst lengths lets the W pass-through stream mark WLAST at the end
// of each burst.
module kernel3_gmem_c_m_axi_write_burst_split #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  parameter int MAX_BURST  = 16,
  parameter int BOUNDARY   = 4096,
  parameter int QDEPTH     = 4
) (
  input logic clk,
  input logic reset,
  input logic clk_en,
  kernel3_gmem_c_m_axi_write_burst_split_if.master bus
);
  localparam int B        = DATA_WIDTH / 8;
  localparam int B_BITS   = $clog2(B);
  localparam int BND_BITS = $clog2(BOUNDARY);
  localparam int BW1      = BND_BITS + 1;
  localparam int LW1      = LEN_WIDTH + 1;
  localparam int PTR_W    = $clog2(QDEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, GEN = 1'b1} state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [ADDR_WIDTH-1:0]  cur_addr_r;
  logic [LEN_WIDTH-1:0]   remaining_r;
  logic [ADDR_WIDTH-1:0]  awaddr_r;
  logic [7:0]             awlen_r;
  logic                   awvalid_r;
  logic [8:0]             q_r [QDEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [8:0]             beat_cnt_r;

  logic [BW1-1:0]         bnd_off_s;
  logic [BW1-1:0]         to_bnd_s;
  logic [LW1-1:0]         to_bnd_ext_s;
  logic [LW1-1:0]         rem_ext_s;
  logic [LW1-1:0]         max_ext_s;
  logic [LW1-1:0]         min_rm_s;
  logic [LW1-1:0]         burst_s;
  logic [8:0]             burst9_s;
  logic [ADDR_WIDTH-1:0]  addr_step_s;
  logic                   q_full_s;
  logic                   wq_valid_s;
  logic [8:0]             head_s;
  logic                   wlast_s;
  logic                   w_hs_s;
  logic                   pop_s;
  logic                   aw_free_s;
  logic                   load_s;
  logic                   req_hs_s;
  logic                   req_start_s;
  logic                   last_load_s;

  // Burst sizing is done in LEN_WIDTH+1 bits so that the min() cannot overflow.
  assign bnd_off_s    = {1'b0, cur_addr_r[BND_BITS-1:0]};
  assign to_bnd_s     = (BW1'(BOUNDARY) - bnd_off_s) >> B_BITS;
  assign to_bnd_ext_s = LW1'(to_bnd_s);
  assign rem_ext_s    = {1'b0, remaining_r};
  assign max_ext_s    = LW1'(MAX_BURST);
  assign min_rm_s     = (rem_ext_s < max_ext_s) ? rem_ext_s : max_ext_s;
  assign burst_s      = (to_bnd_ext_s < min_rm_s) ? to_bnd_ext_s : min_rm_s;
  assign burst9_s     = burst_s[8:0];
  assign addr_step_s  = ADDR_WIDTH'(burst9_s) << B_BITS;

  assign q_full_s    = (count_r == CNT_W'(QDEPTH));
  assign wq_valid_s  = (count_r != {CNT_W{1'b0}});
  assign head_s      = q_r[rd_ptr_r];
  assign wlast_s     = wq_valid_s & (beat_cnt_r == (head_s - 9'd1));
  assign w_hs_s      = bus.in_DATA_VALID & wq_valid_s & bus.in_BUS_WREADY;
  assign pop_s       = w_hs_s & wlast_s;
  assign aw_free_s   = ~awvalid_r | bus.in_BUS_AWREADY;
  assign load_s      = (state_r == GEN) & aw_free_s & ~q_full_s;
  assign req_hs_s    = (state_r == IDLE) & bus.in_REQ_VALID;
  assign req_start_s = req_hs_s & (bus.in_REQ_LEN != {LEN_WIDTH{1'b0}});
  assign last_load_s = load_s & (burst_s == rem_ext_s);

  assign bus.out_REQ_READY   = (state_r == IDLE);
  assign bus.out_DATA_READY  = bus.in_BUS_WREADY & wq_valid_s;
  assign bus.out_BUS_AWADDR  = awaddr_r;
  assign bus.out_BUS_AWLEN   = awlen_r;
  assign bus.out_BUS_AWVALID = awvalid_r;
  assign bus.out_BUS_WDATA   = bus.in_DATA;
  assign bus.out_BUS_WSTRB   = bus.in_STRB;
  assign bus.out_BUS_WLAST   = wlast_s;
  assign bus.out_BUS_WVALID  = bus.in_DATA_VALID & wq_valid_s;

  // Next-state logic: IDLE waits for a non-empty request; GEN runs until the last burst loads.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_start_s) begin
          state_nxt_s = GEN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GEN: begin
        if (last_load_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GEN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else if (clk_en) begin
      state_r <= state_nxt_s;
    end
  end

  // Request cursor: latch on accept, then advance by each loaded burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr_r  <= {ADDR_WIDTH{1'b0}};
      remaining_r <= {LEN_WIDTH{1'b0}};
    end else if (clk_en) begin
      if (req_start_s) begin
        cur_addr_r  <= bus.in_REQ_ADDR;
        remaining_r <= bus.in_REQ_LEN;
      end else if (load_s) begin
        cur_addr_r  <= cur_addr_r + addr_step_s;
        remaining_r <= remaining_r - burst_s[LEN_WIDTH-1:0];
      end
    end
  end

  // AW holding register: loads a new burst or clears on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      awaddr_r  <= {ADDR_WIDTH{1'b0}};
      awlen_r   <= 8'd0;
      awvalid_r <= 1'b0;
    end else if (clk_en) begin
      if (load_s) begin
        awaddr_r  <= cur_addr_r;
        awlen_r   <= burst_s[7:0] - 8'd1;
        awvalid_r <= 1'b1;
      end else if (bus.in_BUS_AWREADY) begin
        awvalid_r <= 1'b0;
      end
    end
  end

  // Burst-length queue: pushed at AW load and popped at the WLAST handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_r[i] <= 9'd0;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clk_en) begin
      if (load_s) begin
        q_r[wr_ptr_r] <= burst9_s;
        wr_ptr_r      <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({load_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Beat position within the burst at the head of the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_r <= 9'd0;
    end else if (clk_en) begin
      if (pop_s) begin
        beat_cnt_r <= 9'd0;
      end else if (w_hs_s) begin
        beat_cnt_r <= beat_cnt_r + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_kernel3_gmem_c_m_axi_write_burst_split.sv
// Scoreboard bench for the gmem_C write burst splitter. A reference model
// breaks each request into bursts with plain arithmetic. Monitors compare
// every AW and W handshake against the queued expectations.
module tb_kernel3_gmem_c_m_axi_write_burst_split;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  logic clk;
  logic reset;
  logic clk_en;

  kernel3_gmem_c_m_axi_write_burst_split_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(32)) bus ();

  kernel3_gmem_c_m_axi_write_burst_split #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(32),
    .MAX_BURST(16), .BOUNDARY(4096), .QDEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .bus(bus.master)
  );

  aw_t exp_aw[$];
  w_t  exp_w[$];
  w_t  src[$];

  int checks = 0;
  int passes = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt = 0;

  int rdy_mode = 0;       // 0: always ready, 1: random, 2: manual
  logic man_awready = 1'b1;
  logic man_wready = 1'b1;
  logic data_en = 1'b0;
  int dense = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: split a request into bursts and queue the expected AW and W traffic.
  task automatic model_req(input longint unsigned addr, input longint unsigned len);
    longint unsigned a;
    longint unsigned rem;
    longint unsigned to_line;
    longint unsigned b;
    logic [31:0] d;
    logic [3:0]  s;
    aw_t e;
    w_t  w;
    a = addr;
    rem = len;
    while (rem > 0) begin
      to_line = (4096 - (a % 4096)) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > to_line) b = to_line;
      e.addr = 32'(a);
      e.len  = 8'(b - 1);
      exp_aw.push_back(e);
      for (longint unsigned i = 0; i < b; i++) begin
        d = $urandom;
        s = 4'($urandom);
        w.data = d;
        w.strb = s;
        w.last = (i == b - 1);
        exp_w.push_back(w);
        w.last = 1'b0;
        src.push_back(w);
      end
      a = a + b * 4;
      rem = rem - b;
    end
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [31:0] len);
    int n;
    logic ok;
    model_req(addr, len);
    @(posedge clk);
    #1;
    bus.in_REQ_ADDR  = addr;
    bus.in_REQ_LEN   = len;
    bus.in_REQ_VALID = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 5000) begin
      @(negedge clk);
      ok = bus.out_REQ_READY;
      n++;
    end
    check("req_accept", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_aw.size() != 0 || exp_w.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_aw_left", 64'(exp_aw.size()), 64'd0);
    check("drain_w_left", 64'(exp_w.size()), 64'd0);
    repeat (5) @(negedge clk);
  endtask

  // Ready generator for AWREADY/WREADY.
  initial begin
    bus.in_BUS_AWREADY = 1'b1;
    bus.in_BUS_WREADY  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin
          bus.in_BUS_AWREADY = 1'b1;
          bus.in_BUS_WREADY  = 1'b1;
        end
        1: begin
          bus.in_BUS_AWREADY = ($urandom_range(0, 3) != 0);
          bus.in_BUS_WREADY  = ($urandom_range(0, 3) != 0);
        end
        default: begin
          bus.in_BUS_AWREADY = man_awready;
          bus.in_BUS_WREADY  = man_wready;
        end
      endcase
    end
  end

  // Beat source: presents src[0] and retires it after an observed handshake.
  initial begin
    logic hs;
    bus.in_DATA       = 32'd0;
    bus.in_STRB       = 4'd0;
    bus.in_DATA_VALID = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.in_DATA_VALID & bus.out_DATA_READY & reset;
      @(posedge clk);
      #1;
      if (hs && src.size() > 0) void'(src.pop_front());
      if (data_en && src.size() > 0 && (dense != 0 || $urandom_range(0, 2) != 0)) begin
        bus.in_DATA       = src[0].data;
        bus.in_STRB       = src[0].strb;
        bus.in_DATA_VALID = 1'b1;
      end else begin
        bus.in_DATA_VALID = 1'b0;
      end
    end
  end

  // Monitor: scoreboard AW and W handshakes, AW stability, and DATA_READY under W backpressure.
  initial begin
    logic        stall_prev;
    logic [31:0] addr_prev;
    logic [7:0]  len_prev;
    aw_t e;
    w_t  w;
    stall_prev = 1'b0;
    addr_prev = 32'd0;
    len_prev = 8'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (stall_prev) begin
          check("aw_hold_valid", {63'd0, bus.out_BUS_AWVALID}, 64'd1);
          check("aw_hold_addr", 64'(bus.out_BUS_AWADDR), 64'(addr_prev));
          check("aw_hold_len", 64'(bus.out_BUS_AWLEN), 64'(len_prev));
        end
        stall_prev = bus.out_BUS_AWVALID & ~bus.in_BUS_AWREADY;
        addr_prev  = bus.out_BUS_AWADDR;
        len_prev   = bus.out_BUS_AWLEN;
        if (bus.out_BUS_AWVALID && bus.in_BUS_AWREADY) begin
          aw_hs_cnt++;
          check("aw_pending", {63'd0, exp_aw.size() != 0}, 64'd1);
          if (exp_aw.size() != 0) begin
            e = exp_aw.pop_front();
            check("aw_addr", 64'(bus.out_BUS_AWADDR), 64'(e.addr));
            check("aw_len", 64'(bus.out_BUS_AWLEN), 64'(e.len));
          end
        end
        if (bus.out_BUS_WVALID && bus.in_BUS_WREADY) begin
          w_hs_cnt++;
          check("w_pending", {63'd0, exp_w.size() != 0}, 64'd1);
          if (exp_w.size() != 0) begin
            w = exp_w.pop_front();
            check("w_data", 64'(bus.out_BUS_WDATA), 64'(w.data));
            check("w_strb", 64'(bus.out_BUS_WSTRB), 64'(w.strb));
            check("w_last", {63'd0, bus.out_BUS_WLAST}, {63'd0, w.last});
          end
        end
        if (!bus.in_BUS_WREADY) begin
          check("dready_when_wready_low", {63'd0, bus.out_DATA_READY}, 64'd0);
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Main sequence: directed scenarios, then randomized requests.
  initial begin
    int aw0;
    int w0;
    int n;
    longint unsigned ra;
    bus.in_REQ_ADDR  = 32'd0;
    bus.in_REQ_LEN   = 32'd0;
    bus.in_REQ_VALID = 1'b0;
    clk_en = 1'b1;
    reset  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", {63'd0, bus.out_BUS_AWVALID}, 64'd0);
    check("rst_awaddr", 64'(bus.out_BUS_AWADDR), 64'd0);
    check("rst_awlen", 64'(bus.out_BUS_AWLEN), 64'd0);
    check("rst_req_ready", {63'd0, bus.out_REQ_READY}, 64'd1);
    check("rst_data_ready", {63'd0, bus.out_DATA_READY}, 64'd0);
    check("rst_wvalid", {63'd0, bus.out_BUS_WVALID}, 64'd0);
    reset = 1'b1;
    data_en = 1'b1;

    // Aligned multi-burst, boundary split, and short tail.
    do_req(32'h0000_0000, 32'd32);
    drain();
    do_req(32'h0000_0FF8, 32'd4);
    drain();
    do_req(32'h0000_0100, 32'd20);
    drain();

    // AW backpressure, then a full queue, then W backpressure.
    rdy_mode = 2;
    man_awready = 1'b0;
    man_wready = 1'b1;
    data_en = 1'b0;
    aw0 = aw_hs_cnt;
    do_req(32'h0000_0200, 32'd80);
    repeat (10) @(negedge clk);
    check("bp_aw_none", 64'(aw_hs_cnt - aw0), 64'd0);
    check("bp_awvalid_held", {63'd0, bus.out_BUS_AWVALID}, 64'd1);
    man_awready = 1'b1;
    repeat (20) @(negedge clk);
    check("bp_aw_qdepth", 64'(aw_hs_cnt - aw0), 64'd4);
    man_wready = 1'b0;
    data_en = 1'b1;
    w0 = w_hs_cnt;
    repeat (10) @(negedge clk);
    check("bp_w_none", 64'(w_hs_cnt - w0), 64'd0);
    man_wready = 1'b1;
    drain();
    check("bp_aw_total", 64'(aw_hs_cnt - aw0), 64'd5);

    // Zero-length request is consumed without traffic.
    aw0 = aw_hs_cnt;
    w0 = w_hs_cnt;
    do_req(32'h0000_0300, 32'd0);
    repeat (20) @(negedge clk);
    check("zero_no_aw", 64'(aw_hs_cnt - aw0), 64'd0);
    check("zero_no_w", 64'(w_hs_cnt - w0), 64'd0);
    check("zero_req_ready", {63'd0, bus.out_REQ_READY}, 64'd1);

    // Reset in the middle of a 16-beat burst whose AW is still pending.
    man_awready = 1'b0;
    w0 = w_hs_cnt;
    do_req(32'h0000_0000, 32'd16);
    n = 0;
    while (w_hs_cnt - w0 < 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_beats_seen", 64'(w_hs_cnt - w0), 64'd6);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_awvalid", {63'd0, bus.out_BUS_AWVALID}, 64'd0);
    check("mid_rst_wvalid", {63'd0, bus.out_BUS_WVALID}, 64'd0);
    check("mid_rst_req_ready", {63'd0, bus.out_REQ_READY}, 64'd1);
    exp_aw.delete();
    exp_w.delete();
    src.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    man_awready = 1'b1;
    rdy_mode = 0;
    do_req(32'h0000_0000, 32'd4);
    drain();

    // Randomized requests with random readiness and sparse beats.
    rdy_mode = 1;
    dense = 0;
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = longint'($urandom_range(1, 4)) * 4096 - 4 * longint'($urandom_range(1, 20));
      end else begin
        ra = longint'($urandom_range(0, 16383)) & ~longint'(3);
      end
      do_req(32'(ra), 32'($urandom_range(0, 60)));
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
